// File: rtl/reg_scoreboard.sv
// Register-file scoreboard for the in-order pipeline: tracks in-flight GPR writes
// between ID issue and WB retire and raises the ID stall on RAW or counter overflow.
module reg_scoreboard #(
    parameter int CNT_WIDTH = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_id_valid,
    input  logic        i_ex_ready,
    input  logic        i_reg_read_en_1,
    input  logic        i_reg_read_en_2,
    input  logic [4:0]  i_reg_addr_1,
    input  logic [4:0]  i_reg_addr_2,
    input  logic        i_reg_write_en,
    input  logic [4:0]  i_reg_write_addr,
    input  logic        i_wb_write_en,
    input  logic [4:0]  i_wb_write_addr,
    output logic        o_stall_request,
    output logic        o_issue_fire,
    output logic [31:0] o_busy_mask,
    output logic [7:0]  o_inflight_total
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam int                   SUM_W   = CNT_WIDTH + 8;

    logic [CNT_WIDTH-1:0] r_cnt [32];
    logic [31:0]          w_retire_hit;
    logic [31:0]          w_issue_hit;
    logic [31:0]          w_pend;
    logic                 w_raw;
    logic                 w_waw_full;
    logic [SUM_W-1:0]     w_sum;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        w_retire_hit = '0;
        w_pend       = '0;
        o_busy_mask  = '0;
        for (int r = 1; r < 32; r++) begin
            w_retire_hit[r] = i_wb_write_en && (i_wb_write_addr == 5'(r));
            o_busy_mask[r]  = (r_cnt[r] != '0);
            w_pend[r]       = (r_cnt[r] != '0) &&
                              !(WB_BYPASS && (r_cnt[r] == CNT_ONE) && w_retire_hit[r]);
        end
    end

    // Pre-issue state only: an instruction's own destination never stalls its reads.
    assign w_raw = (i_reg_read_en_1 && (i_reg_addr_1 != 5'd0) && w_pend[i_reg_addr_1]) ||
                   (i_reg_read_en_2 && (i_reg_addr_2 != 5'd0) && w_pend[i_reg_addr_2]);

    assign w_waw_full = i_reg_write_en && (i_reg_write_addr != 5'd0) &&
                        (r_cnt[i_reg_write_addr] == CNT_MAX) &&
                        !w_retire_hit[i_reg_write_addr];

    assign o_stall_request = i_id_valid && (w_raw || w_waw_full || !i_ex_ready || i_flush);
    assign o_issue_fire    = i_id_valid && !o_stall_request;

    always_comb begin
        w_issue_hit = '0;
        for (int r = 1; r < 32; r++) begin
            w_issue_hit[r] = o_issue_fire && i_reg_write_en && (i_reg_write_addr == 5'(r));
        end
    end

    // NOTE: the running sum is a combinational accumulator, so blocking '=' is correct here;
    // registered state below uses '<=' only.
    always_comb begin
        w_sum = '0;
        for (int r = 1; r < 32; r++) begin
            w_sum = w_sum + SUM_W'(r_cnt[r]);
        end
        o_inflight_total = (w_sum > SUM_W'(255)) ? 8'hFF : w_sum[7:0];
    end

    // NOTE: the counter array is reset explicitly; the hazard logic reads every entry
    // from the first cycle out of reset, so it cannot be left as uninitialised storage.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_issue_hit[r] && !w_retire_hit[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (!w_issue_hit[r] && w_retire_hit[r] && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A retire with nothing pending means the pipeline lost track of a write.
    a_retire_underflow: assert property (@(posedge i_clk) disable iff (i_rst || i_flush)
        !(i_wb_write_en && (i_wb_write_addr != 5'd0) && (r_cnt[i_wb_write_addr] == '0)));
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one bypassing instance and one non-bypassing
// instance share stimulus; expected values are hand-computed per step.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        ex_ready;
    logic        rd_en_1, rd_en_2;
    logic [4:0]  rd_addr_1, rd_addr_2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic        wb_en;
    logic [4:0]  wb_addr;

    logic        stall, fire, stall_nb, fire_nb;
    logic [31:0] busy, busy_nb;
    logic [7:0]  total, total_nb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_WIDTH(2), .WB_BYPASS(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_id_valid(id_valid),
        .i_ex_ready(ex_ready), .i_reg_read_en_1(rd_en_1), .i_reg_read_en_2(rd_en_2),
        .i_reg_addr_1(rd_addr_1), .i_reg_addr_2(rd_addr_2), .i_reg_write_en(wr_en),
        .i_reg_write_addr(wr_addr), .i_wb_write_en(wb_en), .i_wb_write_addr(wb_addr),
        .o_stall_request(stall), .o_issue_fire(fire), .o_busy_mask(busy),
        .o_inflight_total(total)
    );

    reg_scoreboard #(.CNT_WIDTH(2), .WB_BYPASS(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_id_valid(id_valid),
        .i_ex_ready(ex_ready), .i_reg_read_en_1(rd_en_1), .i_reg_read_en_2(rd_en_2),
        .i_reg_addr_1(rd_addr_1), .i_reg_addr_2(rd_addr_2), .i_reg_write_en(wr_en),
        .i_reg_write_addr(wr_addr), .i_wb_write_en(wb_en), .i_wb_write_addr(wb_addr),
        .o_stall_request(stall_nb), .o_issue_fire(fire_nb), .o_busy_mask(busy_nb),
        .o_inflight_total(total_nb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        rd_en_1 = 1'b0; rd_en_2 = 1'b0; rd_addr_1 = '0; rd_addr_2 = '0;
        wr_en = 1'b0; wr_addr = '0; wb_en = 1'b0; wb_addr = '0;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_write(input logic [4:0] a);
        idle(); id_valid = 1'b1; wr_en = 1'b1; wr_addr = a;
        #1; check($sformatf("issue_w%0d_fire", a), 32'(fire), 32'd1);
        tick();
    endtask

    task automatic retire(input logic [4:0] a);
        idle(); wb_en = 1'b1; wb_addr = a;
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_busy", busy, 32'h0);
        check("rst_total", 32'(total), 32'd0);
        check("rst_stall_idle", 32'(stall), 32'd0);
        id_valid = 1'b1; ex_ready = 1'b0; #1;
        check("rst_stall_exready", 32'(stall), 32'd1);
        idle();

        // ADDIU rt=5: busy next cycle, cleared by WB
        issue_write(5'd5);
        idle(); #1;
        check("w5_busy", busy, 32'h0000_0020);
        check("w5_total", 32'(total), 32'd1);
        retire(5'd5);
        check("w5_ret_busy", busy, 32'h0);
        check("w5_ret_total", 32'(total), 32'd0);

        // RAW on port 2 against $8, bypass vs no-bypass
        issue_write(5'd8);
        idle(); id_valid = 1'b1; rd_en_2 = 1'b1; rd_addr_2 = 5'd8; #1;
        check("raw8_stall_c1", 32'(stall), 32'd1);
        check("raw8_fire_c1", 32'(fire), 32'd0);
        tick();
        check("raw8_stall_c2", 32'(stall), 32'd1);
        wb_en = 1'b1; wb_addr = 5'd8; #1;
        check("raw8_wb_fire_byp", 32'(fire), 32'd1);
        check("raw8_wb_fire_nobyp", 32'(fire_nb), 32'd0);
        check("raw8_wb_stall_nobyp", 32'(stall_nb), 32'd1);
        tick();
        wb_en = 1'b0; #1;
        check("raw8_next_fire_nobyp", 32'(fire_nb), 32'd1);
        check("raw8_next_busy", busy, 32'h0);
        check("raw8_next_busy_nobyp", busy_nb, 32'h0);
        tick();

        // Three writes to $3 fill the counter; fourth stalls until a same-cycle retire
        issue_write(5'd3); issue_write(5'd3); issue_write(5'd3);
        idle(); #1;
        check("w3_total3", 32'(total), 32'd3);
        id_valid = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; #1;
        check("w3_full_stall", 32'(stall), 32'd1);
        check("w3_full_fire", 32'(fire), 32'd0);
        tick();
        check("w3_full_hold_total", 32'(total), 32'd3);
        wb_en = 1'b1; wb_addr = 5'd3; #1;
        check("w3_retire_fire", 32'(fire), 32'd1);
        tick();
        idle(); #1;
        check("w3_after_total", 32'(total), 32'd3);
        check("w3_after_busy", busy, 32'h0000_0008);
        retire(5'd3); retire(5'd3); retire(5'd3);
        check("w3_drain_total", 32'(total), 32'd0);

        // $0 is never tracked; JAL sets bit 31
        idle(); id_valid = 1'b1; wr_en = 1'b1; wr_addr = 5'd0;
        rd_en_1 = 1'b1; rd_addr_1 = 5'd0; wb_en = 1'b1; wb_addr = 5'd0; #1;
        check("r0_fire", 32'(fire), 32'd1);
        tick();
        idle(); #1;
        check("r0_busy", busy, 32'h0);
        check("r0_total", 32'(total), 32'd0);
        issue_write(5'd31);
        idle(); #1;
        check("jal_busy", busy, 32'h8000_0000);
        id_valid = 1'b1; rd_en_1 = 1'b1; rd_addr_1 = 5'd0;
        rd_en_2 = 1'b1; rd_addr_2 = 5'd0; #1;
        check("r0_read_no_stall", 32'(stall), 32'd0);
        retire(5'd31);
        check("jal_ret_busy", busy, 32'h0);

        // Same pending register on both ports; read-and-write of a free register
        issue_write(5'd12);
        idle(); id_valid = 1'b1; rd_en_1 = 1'b1; rd_addr_1 = 5'd12;
        rd_en_2 = 1'b1; rd_addr_2 = 5'd12; #1;
        check("dual_port_stall", 32'(stall), 32'd1);
        rd_addr_1 = 5'd10; rd_addr_2 = 5'd10; wr_en = 1'b1; wr_addr = 5'd10; #1;
        check("self_rw_fire", 32'(fire), 32'd1);
        tick();
        idle(); #1;
        check("self_rw_busy", busy, 32'h0000_1400);
        retire(5'd12); retire(5'd10);

        // Flush with pending $4/$9 and a concurrent WB of $4
        issue_write(5'd4); issue_write(5'd9);
        idle(); #1;
        check("fl_pre_busy", busy, 32'h0000_0210);
        check("fl_pre_total", 32'(total), 32'd2);
        flush = 1'b1; wb_en = 1'b1; wb_addr = 5'd4;
        id_valid = 1'b1; rd_en_1 = 1'b1; rd_addr_1 = 5'd9; #1;
        check("fl_stall", 32'(stall), 32'd1);
        check("fl_fire", 32'(fire), 32'd0);
        tick();
        flush = 1'b0; wb_en = 1'b0; #1;
        check("fl_busy", busy, 32'h0);
        check("fl_total", 32'(total), 32'd0);
        check("fl_read9_fire", 32'(fire), 32'd1);
        tick();

        // ex_ready low blocks issue; issue+retire of $6 at count 1 leaves it at 1
        idle(); id_valid = 1'b1; ex_ready = 1'b0; wr_en = 1'b1; wr_addr = 5'd6; #1;
        check("exr_stall", 32'(stall), 32'd1);
        check("exr_fire", 32'(fire), 32'd0);
        tick();
        idle(); #1;
        check("exr_busy", busy, 32'h0);
        check("exr_total", 32'(total), 32'd0);
        issue_write(5'd6);
        idle(); id_valid = 1'b1; wr_en = 1'b1; wr_addr = 5'd6;
        wb_en = 1'b1; wb_addr = 5'd6; #1;
        check("w6_both_fire", 32'(fire), 32'd1);
        tick();
        idle(); #1;
        check("w6_both_busy", busy, 32'h0000_0040);
        check("w6_both_total", 32'(total), 32'd1);
        retire(5'd6);
        check("w6_final_total", 32'(total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-file scoreboard for the in-order MIPS pipeline. Tracks destination registers of instructions issued from ID but not yet written back. Stalls ID whenever the decoded instruction reads a pending register (RAW) or would overflow a register's in-flight counter. Sits beside the ID-stage register address generator: it consumes that block's read/write enables and addresses, plus the WB write port, and drives the ID stall request.

## Interface
Parameters:
- CNT_WIDTH, 2, width of each per-register in-flight counter; the maximum in flight per register is 2^CNT_WIDTH-1.
- WB_BYPASS, 1, when 1 a same-cycle retire of the last pending write clears the hazard combinationally.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  exception/ERET flush from CP0 control; clears all pending state.
- id_valid  input  1  ID holds a valid decoded instruction.
- ex_ready  input  1  EX can accept an instruction this cycle.
- reg_read_en_1, reg_read_en_2  input  1 each  source-port enables from decode.
- reg_addr_1, reg_addr_2  input  5 each  source register addresses.
- reg_write_en  input  1  decoded instruction writes a GPR.
- reg_write_addr  input  5  destination register.
- wb_write_en  input  1  WB stage writes the register file this cycle.
- wb_write_addr  input  5  WB destination.
- stall_request  output  1  hold ID/IF this cycle.
- issue_fire  output  1  instruction leaves ID this cycle.
- busy_mask  output  32  bit r is set while counter[r] != 0; bit 0 is always 0.
- inflight_total  output  8  number of registered writes currently pending, saturating at 255.

## Operation
- State: counter[1..31], each CNT_WIDTH bits. Register 0 is never tracked; any write to $0 is ignored on both the issue and the retire side.
- retire_hit(r) = wb_write_en & wb_write_addr==r & r!=0.
- pend(r) = counter[r]!=0, excluding the case where WB_BYPASS=1 and counter[r]==1 and retire_hit(r).
- raw = (reg_read_en_1 & reg_addr_1!=0 & pend(reg_addr_1)) | (reg_read_en_2 & reg_addr_2!=0 & pend(reg_addr_2)).
- waw_full = reg_write_en & reg_write_addr!=0 & counter[reg_write_addr]==max & ~retire_hit(reg_write_addr).
- stall_request = id_valid & (raw | waw_full | ~ex_ready | flush).
- issue_fire = id_valid & ~stall_request.
- Counter update, per register, with this priority:
  - rst, then flush: all counters go to 0.
  - If issue_fire & reg_write_en targets r and retire_hit(r) in the same cycle: counter unchanged.
  - If only the issue targets r: counter+1. The issue path never wraps, because waw_full blocks it at max.
  - If only the retire hits r: counter-1.
  - A retire arriving while counter[r]==0 is an illegal pipeline event. The counter stays at 0, and the implementation carries a simulation-only assertion for it.
- The two source ports are checked independently. The same address on both ports counts as a single hazard.
- An instruction that reads and writes the same register is checked for RAW against the pre-issue state. Its own write never stalls itself.

## Timing
- stall_request, issue_fire and busy_mask are combinational from the current state and inputs. There is no added latency.
- counter and inflight_total update at the rising edge after the event. A write issued in cycle N makes its destination busy from cycle N+1.
- With WB_BYPASS=1, a dependent instruction issues in the same cycle its producer is in WB. With WB_BYPASS=0, it issues one cycle later.
- Reset values: all counters 0, busy_mask 0, inflight_total 0. stall_request = id_valid & ~ex_ready; it is 0 when id_valid is 0.
- Flush mid-operation: flush asserted in cycle N blocks issue in N, and all counters read 0 in N+1. A WB retire in N is discarded.
- inflight_total changes by +1 on issue, -1 on retire, and 0 when both occur in the same cycle. It is cleared by flush or rst.

## Test plan
- Reset, then issue ADDIU with rt=5 (write_en=1, addr=5) → busy_mask=0x00000020 at the next cycle, inflight_total=1. WB retire of 5 → busy_mask=0, inflight_total=0.
- Issue a write to $8, then present a reader of $8 on port 2 → stall_request=1 for every cycle until WB of $8. With WB_BYPASS=1, issue_fire=1 in the WB cycle; with WB_BYPASS=0, issue_fire=1 in the cycle after.
- Issue three writes to $3 with CNT_WIDTH=2 → counter=3. A fourth write stalls (waw_full). A WB of $3 in the same cycle lets it issue, and counter stays 3.
- Writes and reads of $0 (JAL-like to $31 included) → $0 never sets busy and never stalls. A JAL sets bit 31.
- Pending $4 and $9, then flush while a WB of $4 occurs → the next cycle shows busy_mask=0 and inflight_total=0. A reader of $9 issues immediately.
- ex_ready=0 with no hazard → stall_request=1, issue_fire=0, counters unchanged. Simultaneous issue to $6 and retire of $6 at counter=1 → counter stays 1.
